// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register addresses, exception type codes, reset values
// and the exception decoder used by cp0_reg.
package cp0_reg_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;

  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_IV   = 23;
  localparam int CAUSE_WP   = 22;

  typedef struct packed {
    logic       take;      // non-eret exception: set EXL and ExcCode
    logic       eret;      // clears EXL only
    logic [4:0] exc_code;
  } exc_info_t;

  function automatic exc_info_t decode_exc(input logic [31:0] excepttype);
    exc_info_t info;
    info = '0;
    case (excepttype)
      EXC_INT:  begin info.take = 1'b1; info.exc_code = 5'd0;  end
      EXC_SYS:  begin info.take = 1'b1; info.exc_code = 5'd8;  end
      EXC_RI:   begin info.take = 1'b1; info.exc_code = 5'd10; end
      EXC_TR:   begin info.take = 1'b1; info.exc_code = 5'd13; end
      EXC_OV:   begin info.take = 1'b1; info.exc_code = 5'd12; end
      EXC_ERET: info.eret = 1'b1;
      default:  ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the level timer interrupt. Only instantiated when
// CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  // NOTE: every next-state signal gets a default before any branch so no
  // path leaves it unassigned; a missing default here infers a latch.
  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if ((compare_q != ZERO_WORD) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
    if (we_i == WRITE_ENABLE) begin
      case (waddr_i)
        CP0_REG_COUNT:   count_d = data_i;
        // A Compare write acknowledges the interrupt, even on a matching edge.
        CP0_REG_COMPARE: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers sample their _d values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      count_q     <= ZERO_WORD;
      compare_q   <= ZERO_WORD;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: WB write port, EX read port, MEM exception commit.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004c_0102,
  parameter logic [31:0] CONFIG_RST = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  exc_info_t   exc;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );
`else
  assign count_o     = ZERO_WORD;
  assign compare_o   = ZERO_WORD;
  assign timer_int_o = 1'b0;
`endif

  assign exc = decode_exc(excepttype_i);

  // The write is applied first; exception field updates then override it.
  always_comb begin
    status_d       = status_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    cause_d[15:10] = int_i;

    if (we_i == WRITE_ENABLE) begin
      case (waddr_i)
        CP0_REG_STATUS: status_d = data_i;
        CP0_REG_EPC:    epc_d    = data_i;
        CP0_REG_CAUSE: begin
          cause_d[9:8]      = data_i[9:8];
          cause_d[CAUSE_WP] = data_i[CAUSE_WP];
          cause_d[CAUSE_IV] = data_i[CAUSE_IV];
        end
        default: ;
      endcase
    end

    if (exc.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end else if (exc.take) begin
      // A nested exception keeps the EPC/BD of the outer one.
      if (!status_q[STATUS_EXL]) begin
        epc_d             = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                              : current_inst_addr_i;
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      cause_d[6:2]         = exc.exc_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      status_q <= STATUS_RST;
      cause_q  <= ZERO_WORD;
      epc_q    <= ZERO_WORD;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    data_o = ZERO_WORD;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = count_o;
      CP0_REG_COMPARE: data_o = compare_o;
      CP0_REG_STATUS:  data_o = status_q;
      CP0_REG_CAUSE:   data_o = cause_q;
      CP0_REG_EPC:     data_o = epc_q;
      CP0_REG_PRID:    data_o = PRID_VAL;
      CP0_REG_CONFIG:  data_o = CONFIG_RST;
      default:         ;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_RST;
  assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus randomized traffic
// compared against a rule-level model of the CP0 registers.
module tb_cp0_reg;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [31:0] PRID   = 32'h004c_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;
  localparam logic [31:0] CAUSE_WMASK = 32'h00c0_0300;  // IV, WP, IP[9:8]
  localparam logic [31:0] EXL_BIT = 32'h0000_0002;
  localparam logic [31:0] BD_BIT  = 32'h8000_0000;
  localparam logic [31:0] EXCCODE_MASK = 32'h0000_007c;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count   = 32'h0;
    m_compare = 32'h0;
    m_status  = 32'h1000_0000;
    m_cause   = 32'h0;
    m_epc     = 32'h0;
    m_tint    = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return TIMER_EN ? m_count : 32'h0;
      5'd11:   return TIMER_EN ? m_compare : 32'h0;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return CONFIG;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_tint;
    int          code;
    n_count   = m_count;
    n_compare = m_compare;
    n_tint    = m_tint;
    n_status  = m_status;
    n_epc     = m_epc;
    n_cause   = {m_cause[31:16], int_i, m_cause[9:0]};
    if (TIMER_EN) begin
      n_count = m_count + 32'd1;
      if (m_compare != 0 && m_count == m_compare) n_tint = 1'b1;
      if (we_i && waddr_i == 5'd9) n_count = data_i;
      if (we_i && waddr_i == 5'd11) begin
        n_compare = data_i;
        n_tint    = 1'b0;
      end
    end
    if (we_i && waddr_i == 5'd12) n_status = data_i;
    if (we_i && waddr_i == 5'd14) n_epc = data_i;
    if (we_i && waddr_i == 5'd13) n_cause = (n_cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    case (excepttype_i)
      32'h1:   code = 0;
      32'h8:   code = 8;
      32'ha:   code = 10;
      32'hd:   code = 13;
      32'hc:   code = 12;
      default: code = -1;
    endcase
    if (excepttype_i == 32'he) begin
      n_status = n_status & ~EXL_BIT;
    end else if (code >= 0) begin
      if ((m_status & EXL_BIT) == 0) begin
        n_epc   = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
        n_cause = is_in_delayslot_i ? (n_cause | BD_BIT) : (n_cause & ~BD_BIT);
      end
      n_status = n_status | EXL_BIT;
      n_cause  = (n_cause & ~EXCCODE_MASK) | (32'(code) << 2);
    end
    m_count = n_count; m_compare = n_compare; m_tint = n_tint;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},   count_o,   TIMER_EN ? m_count : 32'h0);
    check({tag, ".compare"}, compare_o, TIMER_EN ? m_compare : 32'h0);
    check({tag, ".status"},  status_o,  m_status);
    check({tag, ".cause"},   cause_o,   m_cause);
    check({tag, ".epc"},     epc_o,     m_epc);
    check({tag, ".config"},  config_o,  CONFIG);
    check({tag, ".prid"},    prid_o,    PRID);
    check({tag, ".tint"},    32'(timer_int_o), TIMER_EN ? 32'(m_tint) : 32'h0);
    check({tag, ".rdata"},   data_o,    model_read(raddr_i));
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 5'd0; data_i = 32'h0;
    excepttype_i = 32'h0; current_inst_addr_i = 32'h0; is_in_delayslot_i = 1'b0;
  endtask

  // One clock: model follows the driven inputs, DUT sampled 1 time unit later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    we_i = 1'b1; waddr_i = a; data_i = d;
    cycle("wr");
    idle_inputs();
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    idle_inputs();
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    cycle("exc");
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; raddr_i = 5'd12; int_i = 6'd0;
    idle_inputs();
    model_reset();
    #12;
    check("rst.status", status_o, 32'h1000_0000);
    check("rst.config", config_o, 32'h0000_8000);
    check("rst.prid",   prid_o,   32'h004c_0102);
    check("rst.count",  count_o,  32'h0);
    check("rst.cause",  cause_o,  32'h0);
    check("rst.epc",    epc_o,    32'h0);
    check("rst.tint",   32'(timer_int_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Count reload and wrap
    raddr_i = 5'd9;
    wr(5'd9, 32'h10);
    check("cnt.load", count_o, TIMER_EN ? 32'h10 : 32'h0);
    cycle("cnt");
    check("cnt.inc1", count_o, TIMER_EN ? 32'h11 : 32'h0);
    cycle("cnt");
    check("cnt.inc2", data_o, TIMER_EN ? 32'h12 : 32'h0);
    wr(5'd9, 32'hffff_ffff);
    cycle("wrap");
    check("cnt.wrap", count_o, 32'h0);

    // Timer interrupt and its acknowledge
    wr(5'd11, 32'h20);
    wr(5'd9, 32'h1e);
    cycle("tmr");
    cycle("tmr");
    check("tmr.before", 32'(timer_int_o), 32'h0);
    cycle("tmr");
    check("tmr.fire", 32'(timer_int_o), TIMER_EN ? 32'h1 : 32'h0);
    cycle("tmr");
    check("tmr.hold", 32'(timer_int_o), TIMER_EN ? 32'h1 : 32'h0);
    wr(5'd11, 32'h4000_0000);
    check("tmr.clear", 32'(timer_int_o), 32'h0);

    // Syscall in a delay slot, then nested overflow, then eret
    raddr_i = 5'd14;
    exc(32'h8, 32'h8000_0104, 1'b1);
    check("sys.epc",  epc_o, 32'h8000_0100);
    check("sys.bd",   32'(cause_o[31]), 32'h1);
    check("sys.exl",  32'(status_o[1]), 32'h1);
    check("sys.code", 32'(cause_o[6:2]), 32'd8);
    exc(32'hc, 32'h200, 1'b0);
    check("ov.epc",  epc_o, 32'h8000_0100);
    check("ov.code", 32'(cause_o[6:2]), 32'd12);
    check("ov.bd",   32'(cause_o[31]), 32'h1);
    exc(32'he, 32'h0, 1'b0);
    check("eret.exl", 32'(status_o[1]), 32'h0);

    // Cause write colliding with a reserved-instruction exception
    raddr_i = 5'd13;
    idle_inputs();
    int_i = 6'b101001;
    we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hffff_ffff;
    excepttype_i = 32'ha; current_inst_addr_i = 32'h300;
    cycle("ri");
    idle_inputs();
    check("ri.ip98",  32'(cause_o[9:8]), 32'h3);
    check("ri.iv",    32'(cause_o[23]), 32'h1);
    check("ri.wp",    32'(cause_o[22]), 32'h1);
    check("ri.code",  32'(cause_o[6:2]), 32'd10);
    check("ri.ip",    32'(cause_o[15:10]), 32'b101001);
    check("ri.epc",   epc_o, 32'h300);
    check("ri.bd",    32'(cause_o[31]), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  addrs [9];
      logic [31:0] types [10];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0, 5'd5};
      types = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3};
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = addrs[$urandom_range(0, 8)];
      data_i = $urandom();
      if ($urandom_range(0, 3) == 0) data_i = data_i & 32'h0000_003f;
      raddr_i = 5'($urandom_range(0, 31));
      int_i = 6'($urandom());
      excepttype_i = types[$urandom_range(0, 9)];
      current_inst_addr_i = $urandom();
      is_in_delayslot_i = 1'($urandom());
      if (i == 200) begin
        // Asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst.status", status_o, 32'h1000_0000);
        check("arst.tint", 32'(timer_int_o), 32'h0);
        check_all("arst");
        #1 rst = 1'b0;
      end
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
